// File: rtl/brq_pkg.sv
// Shared definitions for the branch resolve queue: default widths and the
// per-branch entry captured at prediction time.
package brq_pkg;

  localparam int BRQ_XLEN   = 32;
  localparam int INSN_BYTES = 4;

  typedef struct packed {
    logic [BRQ_XLEN-1:0] pc;
    logic                hit;
    logic [BRQ_XLEN-1:0] tgt;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_q_if.sv
// Fetch-side prediction, execute-side resolution and ATB/redirect outputs
// of the branch resolve queue.
interface branch_resolve_q_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);
  logic                     pred_valid_i;
  logic [XLEN-1:0]          pred_pc_i;
  logic                     pred_hit_i;
  logic [XLEN-1:0]          pred_tgt_i;
  logic                     pred_ready_o;
  logic                     res_valid_i;
  logic                     res_taken_i;
  logic [XLEN-1:0]          res_tgt_i;
  logic                     res_ready_o;
  logic                     retire_valid_o;
  logic [XLEN-1:0]          retire_pc_o;
  logic [XLEN-1:0]          retire_tgt_pc_o;
  logic                     redirect_o;
  logic [XLEN-1:0]          redirect_pc_o;
  logic [$clog2(DEPTH):0]   count_o;
  logic [15:0]              mispredict_cnt_o;

  modport master (
    output pred_valid_i, pred_pc_i, pred_hit_i, pred_tgt_i,
    output res_valid_i, res_taken_i, res_tgt_i,
    input  pred_ready_o, res_ready_o,
    input  retire_valid_o, retire_pc_o, retire_tgt_pc_o,
    input  redirect_o, redirect_pc_o, count_o, mispredict_cnt_o
  );

  modport slave (
    input  pred_valid_i, pred_pc_i, pred_hit_i, pred_tgt_i,
    input  res_valid_i, res_taken_i, res_tgt_i,
    output pred_ready_o, res_ready_o,
    output retire_valid_o, retire_pc_o, retire_tgt_pc_o,
    output redirect_o, redirect_pc_o, count_o, mispredict_cnt_o
  );
endinterface

// File: rtl/brq_fifo.sv
// Synchronous FIFO of branch entries; flush empties it in one edge and
// discards any push presented alongside.
module brq_fifo
  import brq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  brq_entry_t             din,
  output brq_entry_t             dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  brq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH)) && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_resolve_q.sv
// In-order branch resolve queue: compares predictions against execute
// outcomes, issues ATB updates and fetch redirects, flushes on mispredict.
module branch_resolve_q
  import brq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = BRQ_XLEN
) (
  input logic               clk,
  input logic               reset,
  branch_resolve_q_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entry layout comes from the package, so the datapath width must match it.
  if (XLEN != BRQ_XLEN) begin : g_xlen_chk
    $error("branch_resolve_q: XLEN must equal brq_pkg::BRQ_XLEN");
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [XLEN-1:0] fall_through(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSN_BYTES);
  endfunction

  brq_entry_t       push_ent_p0;
  brq_entry_t       head_p0;
  logic [CNT_W-1:0] count_p0;
  logic             push_p0;
  logic             pop_p0;
  logic             tgt_miss_p0;
  logic             retire_p0;
  logic             mispred_p0;

  logic             retire_vld_p1;
  logic [XLEN-1:0]  retire_pc_p1;
  logic [XLEN-1:0]  retire_tgt_p1;
  logic             redirect_vld_p1;
  logic [XLEN-1:0]  redirect_pc_p1;
  logic [15:0]      mp_cnt_p1;

  // Stage p0: handshake, head-of-queue compare
  assign bus.pred_ready_o = (count_p0 != CNT_W'(DEPTH)) && !redirect_vld_p1;
  assign bus.res_ready_o  = (count_p0 != '0);
  assign push_p0          = bus.pred_valid_i && bus.pred_ready_o;
  assign pop_p0           = bus.res_valid_i && bus.res_ready_o;

  assign push_ent_p0.pc  = bus.pred_pc_i;
  assign push_ent_p0.hit = bus.pred_hit_i;
  assign push_ent_p0.tgt = bus.pred_tgt_i;

  assign tgt_miss_p0 = !head_p0.hit || (head_p0.tgt != bus.res_tgt_i);
  assign retire_p0   = pop_p0 && bus.res_taken_i && tgt_miss_p0;
  assign mispred_p0  = pop_p0 && (bus.res_taken_i ? tgt_miss_p0 : head_p0.hit);

  brq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_p0),
    .pop   (pop_p0),
    .flush (mispred_p0),
    .din   (push_ent_p0),
    .dout  (head_p0),
    .count (count_p0)
  );

  // Stage p1: registered ATB update, redirect and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_vld_p1   <= 1'b0;
      retire_pc_p1    <= '0;
      retire_tgt_p1   <= '0;
      redirect_vld_p1 <= 1'b0;
      redirect_pc_p1  <= '0;
      mp_cnt_p1       <= '0;
    end else begin
      retire_vld_p1   <= retire_p0;
      retire_pc_p1    <= retire_p0 ? head_p0.pc : '0;
      retire_tgt_p1   <= retire_p0 ? bus.res_tgt_i : '0;
      redirect_vld_p1 <= mispred_p0;
      if (!mispred_p0)
        redirect_pc_p1 <= '0;
      else if (bus.res_taken_i)
        redirect_pc_p1 <= bus.res_tgt_i;
      else
        redirect_pc_p1 <= fall_through(head_p0.pc);
      if (mispred_p0) mp_cnt_p1 <= sat_inc(mp_cnt_p1);
    end
  end

  assign bus.retire_valid_o   = retire_vld_p1;
  assign bus.retire_pc_o      = retire_pc_p1;
  assign bus.retire_tgt_pc_o  = retire_tgt_p1;
  assign bus.redirect_o       = redirect_vld_p1;
  assign bus.redirect_pc_o    = redirect_pc_p1;
  assign bus.count_o          = count_p0;
  assign bus.mispredict_cnt_o = mp_cnt_p1;

endmodule

// File: tb/tb_branch_resolve_q.sv
// Directed bench for branch_resolve_q: each task drives one scenario and
// checks registered outputs one time unit after the sampling edge.
module tb_branch_resolve_q;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  branch_resolve_q_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bf ();

  branch_resolve_q #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bf.slave)
  );

  task automatic idle();
    bf.pred_valid_i = 1'b0;
    bf.pred_pc_i    = '0;
    bf.pred_hit_i   = 1'b0;
    bf.pred_tgt_i   = '0;
    bf.res_valid_i  = 1'b0;
    bf.res_taken_i  = 1'b0;
    bf.res_tgt_i    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    bf.pred_valid_i = 1'b1;
    bf.pred_pc_i    = pc;
    bf.pred_hit_i   = hit;
    bf.pred_tgt_i   = tgt;
  endtask

  task automatic set_res(input logic taken, input logic [31:0] tgt);
    bf.res_valid_i = 1'b1;
    bf.res_taken_i = taken;
    bf.res_tgt_i   = tgt;
  endtask

  task automatic push(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    set_push(pc, hit, tgt);
    step();
    idle();
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    set_res(taken, tgt);
    step();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_push(32'h80, 1'b1, 32'h90);
    step();
    step();
    idle();
    reset = 1'b0;
    checks++; if (bf.count_o !== 4'd0) $display("FAIL reset_count got %0d exp 0", bf.count_o); else passed++;
    checks++; if (bf.retire_valid_o !== 1'b0) $display("FAIL reset_retire got %b exp 0", bf.retire_valid_o); else passed++;
    checks++; if (bf.redirect_o !== 1'b0) $display("FAIL reset_redirect got %b exp 0", bf.redirect_o); else passed++;
    checks++; if (bf.redirect_pc_o !== 32'h0) $display("FAIL reset_redirect_pc got %h exp 0", bf.redirect_pc_o); else passed++;
    checks++; if (bf.mispredict_cnt_o !== 16'h0) $display("FAIL reset_mpcnt got %0d exp 0", bf.mispredict_cnt_o); else passed++;
    checks++; if (bf.pred_ready_o !== 1'b1) $display("FAIL reset_pred_ready got %b exp 1", bf.pred_ready_o); else passed++;
    checks++; if (bf.res_ready_o !== 1'b0) $display("FAIL reset_res_ready got %b exp 0", bf.res_ready_o); else passed++;
  endtask

  task automatic test_taken_miss();
    push(32'h10, 1'b0, 32'h0);
    checks++; if (bf.count_o !== 4'd1) $display("FAIL miss_count_push got %0d exp 1", bf.count_o); else passed++;
    resolve(1'b1, 32'h1000);
    checks++; if (bf.retire_valid_o !== 1'b1) $display("FAIL miss_retire_valid got %b exp 1", bf.retire_valid_o); else passed++;
    checks++; if (bf.retire_pc_o !== 32'h10) $display("FAIL miss_retire_pc got %h exp 10", bf.retire_pc_o); else passed++;
    checks++; if (bf.retire_tgt_pc_o !== 32'h1000) $display("FAIL miss_retire_tgt got %h exp 1000", bf.retire_tgt_pc_o); else passed++;
    checks++; if (bf.redirect_o !== 1'b1) $display("FAIL miss_redirect got %b exp 1", bf.redirect_o); else passed++;
    checks++; if (bf.redirect_pc_o !== 32'h1000) $display("FAIL miss_redirect_pc got %h exp 1000", bf.redirect_pc_o); else passed++;
    checks++; if (bf.mispredict_cnt_o !== 16'd1) $display("FAIL miss_mpcnt got %0d exp 1", bf.mispredict_cnt_o); else passed++;
    checks++; if (bf.pred_ready_o !== 1'b0) $display("FAIL miss_ready_during_redirect got %b exp 0", bf.pred_ready_o); else passed++;
    step();
    checks++; if (bf.retire_valid_o !== 1'b0) $display("FAIL miss_retire_pulse got %b exp 0", bf.retire_valid_o); else passed++;
    checks++; if (bf.redirect_o !== 1'b0) $display("FAIL miss_redirect_pulse got %b exp 0", bf.redirect_o); else passed++;
    checks++; if (bf.retire_pc_o !== 32'h0) $display("FAIL miss_retire_pc_zero got %h exp 0", bf.retire_pc_o); else passed++;
    checks++; if (bf.redirect_pc_o !== 32'h0) $display("FAIL miss_redirect_pc_zero got %h exp 0", bf.redirect_pc_o); else passed++;
  endtask

  task automatic test_correct();
    push(32'h20, 1'b1, 32'h2000);
    resolve(1'b1, 32'h2000);
    checks++; if (bf.retire_valid_o !== 1'b0) $display("FAIL correct_retire got %b exp 0", bf.retire_valid_o); else passed++;
    checks++; if (bf.redirect_o !== 1'b0) $display("FAIL correct_redirect got %b exp 0", bf.redirect_o); else passed++;
    checks++; if (bf.mispredict_cnt_o !== 16'd1) $display("FAIL correct_mpcnt got %0d exp 1", bf.mispredict_cnt_o); else passed++;
    checks++; if (bf.count_o !== 4'd0) $display("FAIL correct_count got %0d exp 0", bf.count_o); else passed++;
  endtask

  task automatic test_flush();
    push(32'h30, 1'b1, 32'h3000);
    push(32'h40, 1'b0, 32'h0);
    push(32'h50, 1'b0, 32'h0);
    checks++; if (bf.count_o !== 4'd3) $display("FAIL flush_count_pre got %0d exp 3", bf.count_o); else passed++;
    set_res(1'b0, 32'h0);
    set_push(32'h60, 1'b0, 32'h0);
    step();
    idle();
    checks++; if (bf.redirect_o !== 1'b1) $display("FAIL flush_redirect got %b exp 1", bf.redirect_o); else passed++;
    checks++; if (bf.redirect_pc_o !== 32'h34) $display("FAIL flush_redirect_pc got %h exp 34", bf.redirect_pc_o); else passed++;
    checks++; if (bf.retire_valid_o !== 1'b0) $display("FAIL flush_retire got %b exp 0", bf.retire_valid_o); else passed++;
    checks++; if (bf.count_o !== 4'd0) $display("FAIL flush_count got %0d exp 0", bf.count_o); else passed++;
    checks++; if (bf.mispredict_cnt_o !== 16'd2) $display("FAIL flush_mpcnt got %0d exp 2", bf.mispredict_cnt_o); else passed++;
    set_push(32'h70, 1'b0, 32'h0);
    checks++; if (bf.pred_ready_o !== 1'b0) $display("FAIL flush_pred_ready got %b exp 0", bf.pred_ready_o); else passed++;
    step();
    idle();
    checks++; if (bf.count_o !== 4'd0) $display("FAIL flush_push_dropped got %0d exp 0", bf.count_o); else passed++;
    checks++; if (bf.pred_ready_o !== 1'b1) $display("FAIL flush_ready_back got %b exp 1", bf.pred_ready_o); else passed++;
  endtask

  task automatic test_full_back_to_back();
    for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i * 4), 1'b1, 32'h1000 + 32'(i * 4));
    checks++; if (bf.count_o !== 4'd8) $display("FAIL full_count got %0d exp 8", bf.count_o); else passed++;
    checks++; if (bf.pred_ready_o !== 1'b0) $display("FAIL full_pred_ready got %b exp 0", bf.pred_ready_o); else passed++;
    push(32'h999, 1'b0, 32'h0);
    checks++; if (bf.count_o !== 4'd8) $display("FAIL full_extra_dropped got %0d exp 8", bf.count_o); else passed++;
    resolve(1'b1, 32'h1000);
    checks++; if (bf.count_o !== 4'd7) $display("FAIL full_pop_count got %0d exp 7", bf.count_o); else passed++;
    set_res(1'b1, 32'h1004);
    set_push(32'h200, 1'b1, 32'h2200);
    step();
    idle();
    checks++; if (bf.count_o !== 4'd7) $display("FAIL b2b_count got %0d exp 7", bf.count_o); else passed++;
    checks++; if (bf.redirect_o !== 1'b0) $display("FAIL b2b_redirect got %b exp 0", bf.redirect_o); else passed++;
    for (int i = 2; i < DEPTH; i++) begin
      resolve(1'b1, 32'h1000 + 32'(i * 4));
      checks++; if (bf.redirect_o !== 1'b0) $display("FAIL order_entry%0d redirect got %b exp 0", i, bf.redirect_o); else passed++;
    end
    checks++; if (bf.count_o !== 4'd1) $display("FAIL order_count got %0d exp 1", bf.count_o); else passed++;
    resolve(1'b1, 32'hABC0);
    checks++; if (bf.retire_pc_o !== 32'h200) $display("FAIL order_last_pc got %h exp 200", bf.retire_pc_o); else passed++;
    checks++; if (bf.retire_tgt_pc_o !== 32'hABC0) $display("FAIL order_last_tgt got %h exp abc0", bf.retire_tgt_pc_o); else passed++;
    checks++; if (bf.redirect_pc_o !== 32'hABC0) $display("FAIL order_redirect_pc got %h exp abc0", bf.redirect_pc_o); else passed++;
    checks++; if (bf.mispredict_cnt_o !== 16'd3) $display("FAIL order_mpcnt got %0d exp 3", bf.mispredict_cnt_o); else passed++;
    step();
  endtask

  task automatic test_pc_wrap();
    push(32'hFFFF_FFFC, 1'b1, 32'h100);
    resolve(1'b0, 32'h0);
    checks++; if (bf.redirect_o !== 1'b1) $display("FAIL wrap_redirect got %b exp 1", bf.redirect_o); else passed++;
    checks++; if (bf.redirect_pc_o !== 32'h0) $display("FAIL wrap_redirect_pc got %h exp 0", bf.redirect_pc_o); else passed++;
    checks++; if (bf.retire_valid_o !== 1'b0) $display("FAIL wrap_retire got %b exp 0", bf.retire_valid_o); else passed++;
    checks++; if (bf.mispredict_cnt_o !== 16'd4) $display("FAIL wrap_mpcnt got %0d exp 4", bf.mispredict_cnt_o); else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    push(32'h40, 1'b0, 32'h0);
    push(32'h44, 1'b0, 32'h0);
    set_res(1'b1, 32'h5000);
    @(posedge clk);
    #1;
    idle();
    reset = 1'b1;
    set_push(32'h48, 1'b1, 32'h4800);
    step();
    idle();
    reset = 1'b0;
    checks++; if (bf.redirect_o !== 1'b0) $display("FAIL rstmid_redirect got %b exp 0", bf.redirect_o); else passed++;
    checks++; if (bf.retire_valid_o !== 1'b0) $display("FAIL rstmid_retire got %b exp 0", bf.retire_valid_o); else passed++;
    checks++; if (bf.count_o !== 4'd0) $display("FAIL rstmid_count got %0d exp 0", bf.count_o); else passed++;
    checks++; if (bf.redirect_pc_o !== 32'h0) $display("FAIL rstmid_redirect_pc got %h exp 0", bf.redirect_pc_o); else passed++;
    checks++; if (bf.mispredict_cnt_o !== 16'd0) $display("FAIL rstmid_mpcnt got %0d exp 0", bf.mispredict_cnt_o); else passed++;
    step();
    checks++; if (bf.redirect_o !== 1'b0) $display("FAIL rstmid_redirect_after got %b exp 0", bf.redirect_o); else passed++;
    checks++; if (bf.count_o !== 4'd0) $display("FAIL rstmid_count_after got %0d exp 0", bf.count_o); else passed++;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_taken_miss();
    test_correct();
    test_flush();
    test_full_back_to_back();
    test_pc_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_q.md
BRANCH_RESOLVE_Q -- requirements
Module: branch_resolve_q

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of in-flight branch entries (power of 2, >=2).
REQ-002 SHALL have parameter XLEN, default 32, PC/target width.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have pred_valid_i  input  1  fetch issued a branch lookup this cycle.
REQ-006 SHALL have pred_pc_i  input  XLEN  PC of that branch.
REQ-007 SHALL have pred_hit_i  input  1  ATB valid for that lookup.
REQ-008 SHALL have pred_tgt_i  input  XLEN  ATB predicted target.
REQ-009 SHALL have pred_ready_o  output  1  queue accepts a prediction.
REQ-010 SHALL have res_valid_i  input  1  execute resolves oldest branch, in order.
REQ-011 SHALL have res_taken_i  input  1  actual direction.
REQ-012 SHALL have res_tgt_i  input  XLEN  actual taken target.
REQ-013 SHALL have res_ready_o  output  1  queue holds at least one entry.
REQ-014 SHALL have retire_valid_o, retire_pc_o, retire_tgt_pc_o  output  1/XLEN/XLEN  ATB update port.
REQ-015 SHALL have redirect_o, redirect_pc_o  output  1/XLEN  fetch redirect on mispredict.
REQ-016 SHALL have count_o  output  clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have mispredict_cnt_o  output  16  saturating mispredict counter.

Function
REQ-018 SHALL push {pred_pc_i, pred_hit_i, pred_tgt_i} when pred_valid_i && pred_ready_o; pred_ready_o = (count_o != DEPTH) && !redirect_o.
REQ-019 SHALL pop the oldest entry when res_valid_i && res_ready_o; res_ready_o = (count_o != 0); res_valid_i while empty is ignored.
REQ-020 SHALL classify a pop as mispredict when (taken && (!hit || tgt != res_tgt_i)) || (!taken && hit).
REQ-021 SHALL assert retire_valid_o for exactly one cycle, the cycle after a pop with taken && (!hit || tgt != res_tgt_i), with retire_pc_o = entry pc, retire_tgt_pc_o = res_tgt_i; no update for not-taken branches.
REQ-022 SHALL assert redirect_o for exactly one cycle, the cycle after a mispredict pop, with redirect_pc_o = res_tgt_i if taken else entry pc + 4 (modulo 2^XLEN).
REQ-023 SHALL on a mispredict pop flush all remaining entries in the same edge (count_o -> 0) and discard any push presented in that cycle.
REQ-024 SHALL discard pushes while redirect_o is high (pred_ready_o low).
REQ-025 SHALL on simultaneous non-mispredict pop and accepted push keep count_o unchanged and preserve FIFO order.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; full is count_o == DEPTH, empty is count_o == 0.
REQ-027 SHALL increment mispredict_cnt_o by 1 per mispredict pop, saturating at 16'hFFFF.
REQ-028 SHALL hold retire_*_o and redirect_pc_o data at 0 whenever their valid is low.

Reset
REQ-029 SHALL on reset clear pointers, count_o, mispredict_cnt_o, retire_valid_o, redirect_o and all data outputs to 0 at the next edge.
REQ-030 SHALL on reset mid-operation discard all entries and suppress any pending retire/redirect pulse; push/pop in the reset cycle are ignored.

Structure
REQ-031 SHALL place XLEN default, INSN_BYTES (4) and the entry struct {pc, hit, tgt} in shared package brq_pkg.
REQ-032 SHALL implement storage as sub-module brq_fifo (sync FIFO with single-cycle flush input).

Verification
REQ-033 SHALL cover: push pc 0x10 hit=0; resolve taken tgt 0x1000 -> next cycle retire_valid_o=1, retire_pc_o=0x10, retire_tgt_pc_o=0x1000, redirect_o=1, redirect_pc_o=0x1000.
REQ-034 SHALL cover: push pc 0x20 hit=1 tgt 0x2000; resolve taken tgt 0x2000 -> no retire, no redirect, mispredict_cnt_o unchanged.
REQ-035 SHALL cover: push 0x30 hit=1 tgt 0x3000, push 0x40, 0x50; resolve 0x30 not-taken -> redirect_pc_o=0x34, no retire, count_o=0 after edge.
REQ-036 SHALL cover: DEPTH pushes -> pred_ready_o=0, extra push dropped; pop+push same cycle at full-1 -> count stable, order preserved.
REQ-037 SHALL cover: push pc 0xFFFFFFFC hit=1, resolve not-taken -> redirect_pc_o=0x00000000.
REQ-038 SHALL cover: reset asserted one cycle after a mispredict pop -> redirect_o and retire_valid_o stay 0, count_o=0.
